// File: rtl/halt_monitor.sv
// End-of-program detector for a simulated core: watches retirements and stores,
// latches the first halt cause (halt-store, self-loop or timeout) and freezes its counters.
module halt_monitor #(
  parameter logic [31:0] HALT_ADDR  = 32'h0000_00FC,
  parameter int unsigned LOOP_LIMIT = 8,
  parameter logic [31:0] CYCLE_MAX  = 32'd180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        done,
  output logic        pass,
  output logic [1:0]  cause,
  output logic [31:0] exit_code,
  output logic [31:0] cycle_count,
  output logic [31:0] instret
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_STORE = 2'b01;
  localparam logic [1:0] CAUSE_LOOP  = 2'b10;
  localparam logic [1:0] CAUSE_TIME  = 2'b11;

  localparam logic [7:0] LOOP_MAX = 8'(LOOP_LIMIT);

  logic [0:0]  state_q, state_d;
  logic        pass_q, pass_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] exit_q, exit_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] inst_q, inst_d;
  logic [7:0]  loop_q, loop_d;
  logic [31:0] last_pc_q, last_pc_d;

  logic store_hit, loop_hit, time_hit;

  assign store_hit = mem_write && (mem_addr == HALT_ADDR);
  assign loop_hit  = (loop_q == LOOP_MAX);
  assign time_hit  = (cyc_q == CYCLE_MAX);

  // The halting edge itself leaves every counter untouched, so the frozen
  // values describe the run up to the triggering cycle.
  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    cause_d   = cause_q;
    exit_d    = exit_q;
    cyc_d     = cyc_q;
    inst_d    = inst_q;
    loop_d    = loop_q;
    last_pc_d = last_pc_q;

    if (state_q == RUN) begin
      if (store_hit) begin
        state_d = HALTED;
        cause_d = CAUSE_STORE;
        exit_d  = mem_wdata;
        pass_d  = (mem_wdata == 32'd0);
      end else if (loop_hit) begin
        state_d = HALTED;
        cause_d = CAUSE_LOOP;
        pass_d  = 1'b0;
      end else if (time_hit) begin
        state_d = HALTED;
        cause_d = CAUSE_TIME;
        pass_d  = 1'b0;
      end else begin
        cyc_d = cyc_q + 32'd1;
        if (wb_valid) begin
          inst_d    = inst_q + 32'd1;
          last_pc_d = wb_pc;
          // loop_q of zero means no retirement yet, so last_pc_q is meaningless.
          if ((loop_q == 8'd0) || (wb_pc != last_pc_q)) begin
            loop_d = 8'd1;
          end else if (loop_q != LOOP_MAX) begin
            loop_d = loop_q + 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      pass_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
      exit_q    <= 32'd0;
      cyc_q     <= 32'd0;
      inst_q    <= 32'd0;
      loop_q    <= 8'd0;
      last_pc_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      cause_q   <= cause_d;
      exit_q    <= exit_d;
      cyc_q     <= cyc_d;
      inst_q    <= inst_d;
      loop_q    <= loop_d;
      last_pc_q <= last_pc_d;
    end
  end

  assign done        = (state_q == HALTED);
  assign pass        = pass_q;
  assign cause       = cause_q;
  assign exit_code   = exit_q;
  assign cycle_count = cyc_q;
  assign instret     = inst_q;

endmodule

// File: tb/tb_halt_monitor.sv
// Bench for halt_monitor: a behavioural model feeds a scoreboard every cycle,
// with table vectors and hand sequences for halt causes, priority and reset.
module tb_halt_monitor;

  localparam logic [31:0] HALT = 32'h0000_00FC;
  localparam logic [7:0]  LIMIT = 8'd8;
  localparam logic [31:0] CMAX = 32'd180;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wbValid = 1'b0;
  logic [31:0] wbPc = 32'd0;
  logic        memWrite = 1'b0;
  logic [31:0] memAddr = 32'd0;
  logic [31:0] memWdata = 32'd0;
  logic        done, pass;
  logic [1:0]  cause;
  logic [31:0] exitCode, cycleCount, instret;

  int checks = 0;
  int failures = 0;

  halt_monitor dut (
    .clk(clk), .reset(reset), .wb_valid(wbValid), .wb_pc(wbPc),
    .mem_write(memWrite), .mem_addr(memAddr), .mem_wdata(memWdata),
    .done(done), .pass(pass), .cause(cause), .exit_code(exitCode),
    .cycle_count(cycleCount), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        done;
    logic        pass;
    logic [1:0]  cause;
    logic [31:0] exitCode;
    logic [31:0] cycleCount;
    logic [31:0] instret;
  } expT;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        eDone;
    logic [1:0]  eCause;
    logic        ePass;
  } vecT;

  expT sbQ[$];

  // Reference model state
  logic        mHalted, mPass;
  logic [1:0]  mCause;
  logic [31:0] mExit, mCyc, mInst, mLast;
  logic [7:0]  mLoop;

  task automatic modelReset();
    mHalted = 1'b0; mPass = 1'b0; mCause = 2'd0; mExit = 32'd0;
    mCyc = 32'd0; mInst = 32'd0; mLast = 32'd0; mLoop = 8'd0;
    sbQ.delete();
  endtask

  task automatic modelStep(input logic v, input logic [31:0] pc, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
    if (mHalted) return;
    if (w && a == HALT) begin
      mHalted = 1'b1; mCause = 2'd1; mExit = d; mPass = (d == 32'd0);
    end else if (mLoop == LIMIT) begin
      mHalted = 1'b1; mCause = 2'd2; mPass = 1'b0;
    end else if (mCyc == CMAX) begin
      mHalted = 1'b1; mCause = 2'd3; mPass = 1'b0;
    end else begin
      mCyc = mCyc + 32'd1;
      if (v) begin
        mInst = mInst + 32'd1;
        if (mLoop != 8'd0 && pc == mLast) mLoop = (mLoop == LIMIT) ? LIMIT : mLoop + 8'd1;
        else mLoop = 8'd1;
        mLast = pc;
      end
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    expT e;
    if (sbQ.size() == 0) begin
      checks++; failures++;
      $display("[TB] FAIL scoreboard_empty actual=0 expected=1");
      return;
    end
    e = sbQ.pop_front();
    checkVal("done", {31'd0, done}, {31'd0, e.done});
    checkVal("pass", {31'd0, pass}, {31'd0, e.pass});
    checkVal("cause", {30'd0, cause}, {30'd0, e.cause});
    checkVal("exit_code", exitCode, e.exitCode);
    checkVal("cycle_count", cycleCount, e.cycleCount);
    checkVal("instret", instret, e.instret);
  endtask

  // One clock: drive at negedge, predict, then compare just after the posedge.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic w,
                               input logic [31:0] a, input logic [31:0] d);
    expT e;
    wbValid = v; wbPc = pc; memWrite = w; memAddr = a; memWdata = d;
    modelStep(v, pc, w, a, d);
    e.done = mHalted; e.pass = mPass; e.cause = mCause; e.exitCode = mExit;
    e.cycleCount = mCyc; e.instret = mInst;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic checkZeros(input string tag);
    checkVal({tag, "_done"}, {31'd0, done}, 32'd0);
    checkVal({tag, "_pass"}, {31'd0, pass}, 32'd0);
    checkVal({tag, "_cause"}, {30'd0, cause}, 32'd0);
    checkVal({tag, "_exit"}, exitCode, 32'd0);
    checkVal({tag, "_cyc"}, cycleCount, 32'd0);
    checkVal({tag, "_inst"}, instret, 32'd0);
  endtask

  // Asynchronous reset pulse starting mid-cycle; held across one rising edge.
  task automatic applyReset();
    wbValid = 1'b0; memWrite = 1'b0;
    reset = 1'b1;
    #1;
    modelReset();
    checkZeros("rst_async");
    @(posedge clk);
    #1;
    checkVal("rst_hold_cyc", cycleCount, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  vecT tbl[4];

  initial begin
    tbl[0] = '{1'b1, 32'h10, 1'b1, 32'hF8, 32'd3, 1'b0, 2'd0, 1'b0};
    tbl[1] = '{1'b1, 32'h14, 1'b0, 32'h0,  32'd0, 1'b0, 2'd0, 1'b0};
    tbl[2] = '{1'b0, 32'h0,  1'b1, 32'hFC, 32'd3, 1'b1, 2'd1, 1'b0};
    tbl[3] = '{1'b1, 32'h18, 1'b1, 32'hFC, 32'd0, 1'b1, 2'd1, 1'b0};

    // Power-on reset, released at 10 ns
    #1 reset = 1'b1;
    #1;
    modelReset();
    checkZeros("por");
    @(negedge clk);
    reset = 1'b0;

    // 20 distinct retirements, idle to cycle 25, then passing halt store
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'h100 + 32'(i * 4), 1'b0, 32'd0, 32'd0);
    idle(5);
    applyStimulus(1'b0, 32'd0, 1'b1, HALT, 32'd0);
    checkVal("s1_done", {31'd0, done}, 32'd1);
    checkVal("s1_cause", {30'd0, cause}, 32'd1);
    checkVal("s1_pass", {31'd0, pass}, 32'd1);
    checkVal("s1_instret", instret, 32'd20);
    checkVal("s1_cycles", cycleCount, 32'd25);
    applyStimulus(1'b1, 32'h200, 1'b1, HALT, 32'd7);
    idle(2);

    // Table: non-halt address, then failing exit code, then ignored later store
    applyReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(tbl[i].v, tbl[i].pc, tbl[i].w, tbl[i].a, tbl[i].d);
      checkVal($sformatf("tbl%0d_done", i), {31'd0, done}, {31'd0, tbl[i].eDone});
      checkVal($sformatf("tbl%0d_cause", i), {30'd0, cause}, {30'd0, tbl[i].eCause});
      checkVal($sformatf("tbl%0d_pass", i), {31'd0, pass}, {31'd0, tbl[i].ePass});
    end
    checkVal("tbl_exit", exitCode, 32'd3);

    // Self-loop with bubbles between repeats
    applyReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h40, 1'b0, 32'd0, 32'd0);
      if (i < 7) idle(1);
    end
    checkVal("loop_pre_done", {31'd0, done}, 32'd0);
    idle(1);
    checkVal("loop_done", {31'd0, done}, 32'd1);
    checkVal("loop_cause", {30'd0, cause}, 32'd2);
    checkVal("loop_pass", {31'd0, pass}, 32'd0);

    // Seven repeats, then a new PC restarts the run length from 1
    applyReset();
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 32'h40, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 32'h44, 1'b0, 32'd0, 32'd0);
    idle(1);
    checkVal("loop_restart_done", {31'd0, done}, 32'd0);
    applyStimulus(1'b1, 32'h44, 1'b0, 32'd0, 32'd0);
    idle(1);
    checkVal("loop_restart_cause", {30'd0, cause}, 32'd2);

    // Timeout with no halt event, then frozen
    applyReset();
    idle(180);
    checkVal("to_pre_done", {31'd0, done}, 32'd0);
    checkVal("to_pre_cyc", cycleCount, 32'd180);
    idle(1);
    checkVal("to_done", {31'd0, done}, 32'd1);
    checkVal("to_cause", {30'd0, cause}, 32'd3);
    checkVal("to_cyc", cycleCount, 32'd180);
    applyStimulus(1'b1, 32'h80, 1'b1, HALT, 32'd0);
    idle(3);
    checkVal("to_frozen_cyc", cycleCount, 32'd180);
    checkVal("to_frozen_cause", {30'd0, cause}, 32'd3);

    // Halt store coinciding with a pending self-loop halt: store wins
    applyReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h80, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b1, 32'h80, 1'b1, HALT, 32'd5);
    checkVal("prio_cause", {30'd0, cause}, 32'd1);
    checkVal("prio_exit", exitCode, 32'd5);
    checkVal("prio_instret", instret, 32'd8);

    // Reset while halted clears immediately and counting restarts
    applyReset();
    idle(1);
    checkVal("restart_cyc", cycleCount, 32'd1);
    checkVal("restart_done", {31'd0, done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
